// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: position scanner producing the 3-bit select code for a
// decoder_3x8. Steps through positions 0..NUM_POS-1, holding each for DWELL
// clock cycles. Supports up/down scanning, pause, preload, and continuous or
// single-sweep operation.
//
// Ports:
//   clk       - system clock, rising-edge active
//   rst_n     - asynchronous active-low reset
//   start     - begin a scan (sampled only in IDLE)
//   stop      - abort the scan and return to IDLE
//   pause     - freeze the dwell counter while scanning
//   dir       - 0 = count up, 1 = count down (sampled at each advance)
//   single    - 0 = continuous, 1 = one sweep only (sampled at start)
//   load      - preload sel from load_val (clamped to NUM_POS-1)
//   load_val  - preload value
//   sel       - current position, feeds decoder_3x8 data_in
//   sel_valid - high while scanning
//   wrap      - one-cycle pulse when a wrapped position first appears
//   done      - one-cycle pulse when a single sweep completes
module decoder_scan_ctrl #(
   parameter int unsigned DWELL   = 4,
   parameter int unsigned NUM_POS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       dir,
   input  logic       single,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic [2:0] sel,
   output logic       sel_valid,
   output logic       wrap,
   output logic       done
);

   localparam int unsigned CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [2:0] POS_LAST = 3'(NUM_POS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             single_q, single_nxt;
   logic [2:0]       sel_nxt;
   logic             sel_valid_nxt, wrap_nxt, done_nxt;
   logic [2:0]       load_pos_c;
   logic             at_edge_c;

   // Preload clamped so sel never holds an unused code.
   assign load_pos_c = ({1'b0, load_val} >= 4'(NUM_POS)) ? POS_LAST : load_val;

   // Current position is the last one in the present scan direction.
   assign at_edge_c = dir ? (sel == 3'd0) : (sel == POS_LAST);

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      single_nxt    = single_q;
      sel_nxt       = sel;
      sel_valid_nxt = 1'b0;
      wrap_nxt      = 1'b0;
      done_nxt      = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               // Start position wins over a same-edge load.
               state_nxt     = SCAN;
               sel_nxt       = dir ? POS_LAST : 3'd0;
               cnt_nxt       = '0;
               single_nxt    = single;
               sel_valid_nxt = 1'b1;
            end else if (load && !stop) begin
               sel_nxt = load_pos_c;
               cnt_nxt = '0;
            end
         end

         SCAN: begin
            sel_valid_nxt = 1'b1;
            if (stop) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               sel_valid_nxt = 1'b0;
            end else if (load) begin
               sel_nxt = load_pos_c;
               cnt_nxt = '0;
            end else if (!pause) begin
               if (cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  if (at_edge_c && single_q) begin
                     // Sweep complete: hold the last position.
                     state_nxt     = DONE;
                     sel_valid_nxt = 1'b0;
                     done_nxt      = 1'b1;
                  end else if (at_edge_c) begin
                     sel_nxt  = dir ? POS_LAST : 3'd0;
                     wrap_nxt = 1'b1;
                  end else begin
                     sel_nxt = dir ? 3'(sel - 3'd1) : 3'(sel + 3'd1);
                  end
               end else begin
                  cnt_nxt = CNT_W'(cnt + CNT_W'(1));
               end
            end
         end

         DONE: begin
            state_nxt = IDLE;
            if (load && !stop) begin
               sel_nxt = load_pos_c;
               cnt_nxt = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         single_q  <= 1'b0;
         sel       <= 3'd0;
         sel_valid <= 1'b0;
         wrap      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         single_q  <= single_nxt;
         sel       <= sel_nxt;
         sel_valid <= sel_valid_nxt;
         wrap      <= wrap_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl. Three instances share one stimulus
// set: u_d (NUM_POS=8, DWELL=4), u_s (NUM_POS=5, DWELL=2), u_l (NUM_POS=5,
// DWELL=4). Each scenario resets first and checks only its own instance.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, pause, dir, single, load;
   logic [2:0] load_val;

   logic [2:0] d_sel, s_sel, l_sel;
   logic       d_vld, s_vld, l_vld;
   logic       d_wrap, s_wrap, l_wrap;
   logic       d_done, s_done, l_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decoder_scan_ctrl #(.DWELL(4), .NUM_POS(8)) u_d (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .dir(dir), .single(single), .load(load), .load_val(load_val),
      .sel(d_sel), .sel_valid(d_vld), .wrap(d_wrap), .done(d_done));

   decoder_scan_ctrl #(.DWELL(2), .NUM_POS(5)) u_s (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .dir(dir), .single(single), .load(load), .load_val(load_val),
      .sel(s_sel), .sel_valid(s_vld), .wrap(s_wrap), .done(s_done));

   decoder_scan_ctrl #(.DWELL(4), .NUM_POS(5)) u_l (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .dir(dir), .single(single), .load(load), .load_val(load_val),
      .sel(l_sel), .sel_valid(l_vld), .wrap(l_wrap), .done(l_done));

   // Advance one clock; outputs are then stable 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; stop = 0; pause = 0; dir = 0; single = 0; load = 0;
      load_val = 3'd0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({d_sel, d_vld, d_wrap, d_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_state: got sel=%0d vld=%b wrap=%b done=%b, want all 0",
                  d_sel, d_vld, d_wrap, d_done);
      end
   endtask

   // Continuous up-scan over 8 positions, each held 4 cycles, then wrap 7->0.
   task automatic test_continuous_up();
      logic [7:0] onehot, want_oh;
      do_reset();
      start = 1; dir = 0; single = 0;
      tick();
      start = 0;
      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < 4; c++) begin
            onehot  = 8'd1 << d_sel;
            want_oh = 8'd1 << p;
            checks++;
            if (d_sel !== 3'(p) || d_vld !== 1'b1 || d_wrap !== 1'b0 || onehot !== want_oh) begin
               errors++;
               $display("FAIL up_scan p%0d c%0d: got sel=%0d vld=%b wrap=%b oh=%b, want sel=%0d vld=1 wrap=0 oh=%b",
                        p, c, d_sel, d_vld, d_wrap, onehot, p, want_oh);
            end
            tick();
         end
      end
      checks++;
      if (d_sel !== 3'd0 || d_wrap !== 1'b1 || d_vld !== 1'b1) begin
         errors++;
         $display("FAIL up_wrap: got sel=%0d wrap=%b vld=%b, want sel=0 wrap=1 vld=1",
                  d_sel, d_wrap, d_vld);
      end
      tick();
      checks++;
      if (d_sel !== 3'd0 || d_wrap !== 1'b0) begin
         errors++;
         $display("FAIL up_wrap_pulse_len: got sel=%0d wrap=%b, want sel=0 wrap=0",
                  d_sel, d_wrap);
      end
   endtask

   // NUM_POS=5, DWELL=2, single sweep down: 4,3,2,1,0 then done.
   task automatic test_single_down();
      do_reset();
      start = 1; dir = 1; single = 1;
      tick();
      start = 0; single = 0;
      for (int p = 4; p >= 0; p--) begin
         for (int c = 0; c < 2; c++) begin
            checks++;
            if (s_sel !== 3'(p) || s_vld !== 1'b1 || s_wrap !== 1'b0 || s_done !== 1'b0) begin
               errors++;
               $display("FAIL single_down p%0d c%0d: got sel=%0d vld=%b wrap=%b done=%b, want sel=%0d vld=1 wrap=0 done=0",
                        p, c, s_sel, s_vld, s_wrap, s_done, p);
            end
            tick();
         end
      end
      checks++;
      if (s_done !== 1'b1 || s_sel !== 3'd0 || s_vld !== 1'b0 || s_wrap !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got done=%b sel=%0d vld=%b wrap=%b, want done=1 sel=0 vld=0 wrap=0",
                  s_done, s_sel, s_vld, s_wrap);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (s_done !== 1'b0 || s_vld !== 1'b0 || s_sel !== 3'd0 || s_wrap !== 1'b0) begin
            errors++;
            $display("FAIL single_idle %0d: got done=%b vld=%b sel=%0d wrap=%b, want done=0 vld=0 sel=0 wrap=0",
                     i, s_done, s_vld, s_sel, s_wrap);
         end
      end
   endtask

   // Pause 3 cycles during sel=2 stretches it to 7 cycles; then stop+load.
   task automatic test_pause_stop();
      int held;
      do_reset();
      start = 1; dir = 0; single = 0;
      tick();
      start = 0;
      for (int i = 0; i < 8; i++) tick();
      held = 0;
      // sel=2 first cycle, plus one unpaused count
      for (int i = 0; i < 2; i++) begin
         if (d_sel == 3'd2) held++;
         tick();
      end
      pause = 1;
      for (int i = 0; i < 3; i++) begin
         if (d_sel == 3'd2) held++;
         tick();
      end
      pause = 0;
      for (int i = 0; i < 6; i++) begin
         if (d_sel == 3'd2) held++;
         if (d_sel == 3'd3) break;
         tick();
      end
      checks++;
      if (held != 7 || d_sel !== 3'd3) begin
         errors++;
         $display("FAIL pause_hold: got sel2 cycles=%0d now sel=%0d, want 7 cycles then sel=3",
                  held, d_sel);
      end
      stop = 1; load = 1; load_val = 3'd6;
      tick();
      stop = 0; load = 0;
      checks++;
      if (d_sel !== 3'd3 || d_vld !== 1'b0 || d_wrap !== 1'b0 || d_done !== 1'b0) begin
         errors++;
         $display("FAIL stop_over_load: got sel=%0d vld=%b wrap=%b done=%b, want sel=3 vld=0 wrap=0 done=0",
                  d_sel, d_vld, d_wrap, d_done);
      end
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (d_sel !== 3'd3 || d_vld !== 1'b0) begin
         errors++;
         $display("FAIL stop_stays_idle: got sel=%0d vld=%b, want sel=3 vld=0", d_sel, d_vld);
      end
   endtask

   // Load of 6 with NUM_POS=5 clamps to 4, holds DWELL, then wraps to 0.
   task automatic test_load_clamp();
      do_reset();
      start = 1; dir = 0; single = 0;
      tick();
      start = 0;
      load = 1; load_val = 3'd6;
      tick();
      load = 0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (l_sel !== 3'd4 || l_vld !== 1'b1 || l_wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp c%0d: got sel=%0d vld=%b wrap=%b, want sel=4 vld=1 wrap=0",
                     c, l_sel, l_vld, l_wrap);
         end
         tick();
      end
      checks++;
      if (l_sel !== 3'd0 || l_wrap !== 1'b1) begin
         errors++;
         $display("FAIL load_wrap: got sel=%0d wrap=%b, want sel=0 wrap=1", l_sel, l_wrap);
      end
   endtask

   // Asynchronous reset mid-dwell at sel=5 clears outputs without a clock edge.
   task automatic test_async_reset();
      do_reset();
      start = 1; dir = 0; single = 0;
      tick();
      start = 0;
      for (int i = 0; i < 21; i++) tick();
      checks++;
      if (d_sel !== 3'd5 || d_vld !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_pos: got sel=%0d vld=%b, want sel=5 vld=1", d_sel, d_vld);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (d_sel !== 3'd0 || d_vld !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got sel=%0d vld=%b, want sel=0 vld=0", d_sel, d_vld);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (d_sel !== 3'd0 || d_vld !== 1'b0 || d_wrap !== 1'b0 || d_done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got sel=%0d vld=%b wrap=%b done=%b, want all 0",
                  d_sel, d_vld, d_wrap, d_done);
      end
      start = 1;
      tick();
      start = 0;
      checks++;
      if (d_sel !== 3'd0 || d_vld !== 1'b1) begin
         errors++;
         $display("FAIL restart: got sel=%0d vld=%b, want sel=0 vld=1", d_sel, d_vld);
      end
   endtask

   // dir flips 0->1 one cycle before the advance at sel=3: next sel is 2.
   task automatic test_dir_change();
      do_reset();
      start = 1; dir = 0; single = 0;
      tick();
      start = 0;
      for (int i = 0; i < 14; i++) tick();
      checks++;
      if (d_sel !== 3'd3) begin
         errors++;
         $display("FAIL dir_pre: got sel=%0d, want 3", d_sel);
      end
      dir = 1;
      tick();
      checks++;
      if (d_sel !== 3'd3 || d_wrap !== 1'b0) begin
         errors++;
         $display("FAIL dir_hold: got sel=%0d wrap=%b, want sel=3 wrap=0", d_sel, d_wrap);
      end
      tick();
      checks++;
      if (d_sel !== 3'd2 || d_wrap !== 1'b0 || d_vld !== 1'b1) begin
         errors++;
         $display("FAIL dir_advance: got sel=%0d wrap=%b vld=%b, want sel=2 wrap=0 vld=1",
                  d_sel, d_wrap, d_vld);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (d_sel !== 3'd1) begin
         errors++;
         $display("FAIL dir_next: got sel=%0d, want 1", d_sel);
      end
   endtask

   initial begin
      test_reset();
      test_continuous_up();
      test_single_down();
      test_pause_stop();
      test_load_clamp();
      test_async_reset();
      test_dir_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
